// File: rtl/rf_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : rf_adc_capture
// Description : Multi-channel ADC snapshot engine. Continuously records all
//               enabled channels into a shared circular buffer with a
//               programmable pre-trigger depth, freezes on a trigger, then
//               replays each enabled channel as one AXI4-Stream packet.
// Ports       : adc_usr_clk/adc_usr_rst  - clock, sync active-high reset
//               arm/abort/sw_trig/ext_trig - capture control
//               pre_len, ch_en            - capture setup, sampled at arm
//               s_tdata/s_tvalid/s_tready - ADC input (never stalls)
//               m_t*                      - readout stream, tuser = channel
//               busy, done, state         - status
// Revision    : 1.0 - initial release
// ============================================================================
module rf_adc_capture #(
    parameter int CH_NUM = 6,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                     adc_usr_clk,
    input  logic                     adc_usr_rst,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     sw_trig,
    input  logic                     ext_trig,
    input  logic [AW-1:0]            pre_len,
    input  logic [CH_NUM-1:0]        ch_en,
    input  logic [CH_NUM*DATA_W-1:0] s_tdata,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic                     m_tlast,
    output logic [2:0]               m_tuser,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               state
);

    localparam logic [2:0]    c_idle  = 3'd0;
    localparam logic [2:0]    c_fill  = 3'd1;
    localparam logic [2:0]    c_armed = 3'd2;
    localparam logic [2:0]    c_post  = 3'd3;
    localparam logic [2:0]    c_read  = 3'd4;
    localparam logic [AW:0]   c_depth = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);

    // Capture control
    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [AW-1:0]     r_pre_len;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_start_ptr;
    logic [AW-1:0]     w_start_calc;
    logic [CH_NUM-1:0] r_ch_en;
    logic [AW:0]       r_cnt;
    logic [AW:0]       w_cnt_inc;
    logic [AW:0]       w_post_len;
    logic              r_ext_q;
    logic              w_trig;
    logic              w_wr_en;
    logic              w_read_done;
    logic              w_enter_read;
    logic              r_busy;
    logic              r_done;

    // Buffer: all lanes share one address, so one wide word per beat
    logic [CH_NUM*DATA_W-1:0] r_mem [DEPTH];
    logic [CH_NUM*DATA_W-1:0] r_ram_q;

    // Read issue stage
    logic          r_iss_active;
    logic [2:0]    r_iss_ch;
    logic [AW-1:0] r_iss_idx;
    logic [AW-1:0] r_iss_addr;
    logic [2:0]    w_first_ch;
    logic [2:0]    w_next_ch;
    logic          w_next_found;
    logic          w_issue;

    // RAM output stage
    logic              r_rd_valid;
    logic              r_rd_last;
    logic [2:0]        r_rd_user;
    logic [DATA_W-1:0] w_lane;

    // 2-entry output skid buffer
    logic [DATA_W-1:0] r_fq_data [2];
    logic              r_fq_last [2];
    logic [2:0]        r_fq_user [2];
    logic              r_fq_wp;
    logic              r_fq_rp;
    logic [1:0]        r_fq_cnt;
    logic              w_pop;
    logic [2:0]        w_occ;

    assign s_tready = 1'b1;
    assign state    = r_state;
    assign busy     = r_busy;
    assign done     = r_done;
    assign m_tvalid = (r_fq_cnt != 2'd0);
    assign m_tdata  = r_fq_data[r_fq_rp];
    assign m_tlast  = r_fq_last[r_fq_rp];
    assign m_tuser  = r_fq_user[r_fq_rp];

    assign w_wr_en      = s_tvalid && ((r_state == c_fill) || (r_state == c_armed) ||
                                       (r_state == c_post));
    assign w_trig       = sw_trig | (ext_trig & ~r_ext_q);
    assign w_cnt_inc    = r_cnt + 1'b1;
    assign w_post_len   = c_depth - {1'b0, r_pre_len};
    assign w_start_calc = r_wr_ptr - r_pre_len;
    assign w_read_done  = (r_state == c_read) && !r_iss_active && !r_rd_valid &&
                          (r_fq_cnt == 2'd0);
    assign w_enter_read = (w_state_nxt == c_read) && (r_state != c_read);
    assign w_pop        = m_tvalid & m_tready;
    assign w_occ        = 3'(r_fq_cnt) + 3'(r_rd_valid);
    // A read is issued only if its data is guaranteed a skid slot on arrival;
    // counting this cycle's pop keeps the pipe at one beat per cycle.
    assign w_issue      = (r_state == c_read) && r_iss_active && !abort &&
                          ((w_occ - 3'(w_pop)) < 3'd2);

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_idle;
        end else begin
            case (r_state)
                c_idle:  if (arm) w_state_nxt = (pre_len == '0) ? c_armed : c_fill;
                c_fill:  if (w_wr_en && (w_cnt_inc == {1'b0, r_pre_len})) w_state_nxt = c_armed;
                c_armed: if (w_trig) w_state_nxt = (w_wr_en && (w_post_len == (AW+1)'(1))) ?
                                                   c_read : c_post;
                c_post:  if (w_wr_en && (w_cnt_inc == w_post_len)) w_state_nxt = c_read;
                c_read:  if (w_read_done) w_state_nxt = c_idle;
                default: w_state_nxt = c_idle;
            endcase
        end
    end

    // Lowest enabled channel, and the next enabled channel above the current one
    always_comb begin
        w_first_ch   = 3'd0;
        w_next_ch    = 3'd0;
        w_next_found = 1'b0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (r_ch_en[k]) begin
                w_first_ch = 3'(k);
                if (3'(k) > r_iss_ch) begin
                    w_next_ch    = 3'(k);
                    w_next_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_lane = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (r_rd_user == 3'(k)) w_lane = r_ram_q[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge adc_usr_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= s_tdata;
        if (w_issue) r_ram_q <= r_mem[r_iss_addr];
    end

    always_ff @(posedge adc_usr_clk) begin
        if (adc_usr_rst) begin
            r_state      <= c_idle;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ext_q      <= 1'b0;
            r_pre_len    <= '0;
            r_ch_en      <= '0;
            r_wr_ptr     <= '0;
            r_start_ptr  <= '0;
            r_cnt        <= '0;
            r_iss_active <= 1'b0;
            r_iss_ch     <= 3'd0;
            r_iss_idx    <= '0;
            r_iss_addr   <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_user    <= 3'd0;
            r_fq_wp      <= 1'b0;
            r_fq_rp      <= 1'b0;
            r_fq_cnt     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_fq_data[i] <= '0;
                r_fq_last[i] <= 1'b0;
                r_fq_user[i] <= 3'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_idle);
            r_done  <= w_read_done && !abort;
            r_ext_q <= ext_trig;

            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;

            case (r_state)
                c_idle: begin
                    // pre_len is AW bits wide, so it can never exceed DEPTH-1
                    if (arm && !abort) begin
                        r_pre_len <= pre_len;
                        r_ch_en   <= ch_en;
                        r_wr_ptr  <= '0;
                        r_cnt     <= '0;
                    end
                end
                c_fill, c_post: begin
                    if (w_wr_en) r_cnt <= w_cnt_inc;
                end
                c_armed: begin
                    if (w_trig) begin
                        r_start_ptr <= w_start_calc;
                        // The beat written in the trigger cycle is post-sample 0
                        r_cnt       <= w_wr_en ? (AW+1)'(1) : '0;
                    end
                end
                default: ;
            endcase

            if (abort) begin
                r_iss_active <= 1'b0;
            end else if (w_enter_read) begin
                r_iss_active <= |r_ch_en;
                r_iss_ch     <= w_first_ch;
                r_iss_idx    <= '0;
                // From ARMED the start pointer is being registered this same edge
                r_iss_addr   <= (r_state == c_armed) ? w_start_calc : r_start_ptr;
            end else if (w_issue) begin
                if (r_iss_idx == c_last) begin
                    if (w_next_found) begin
                        r_iss_ch   <= w_next_ch;
                        r_iss_idx  <= '0;
                        r_iss_addr <= r_start_ptr;
                    end else begin
                        r_iss_active <= 1'b0;
                    end
                end else begin
                    r_iss_idx  <= r_iss_idx + 1'b1;
                    r_iss_addr <= r_iss_addr + 1'b1;
                end
            end

            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_last <= (r_iss_idx == c_last);
                r_rd_user <= r_iss_ch;
            end

            if (abort) begin
                r_fq_wp  <= 1'b0;
                r_fq_rp  <= 1'b0;
                r_fq_cnt <= 2'd0;
            end else begin
                if (r_rd_valid) begin
                    r_fq_data[r_fq_wp] <= w_lane;
                    r_fq_last[r_fq_wp] <= r_rd_last;
                    r_fq_user[r_fq_wp] <= r_rd_user;
                    r_fq_wp            <= ~r_fq_wp;
                end
                if (w_pop) r_fq_rp <= ~r_fq_rp;
                r_fq_cnt <= r_fq_cnt + 2'(r_rd_valid) - 2'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_adc_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_adc_capture
// Description : Self-checking bench for rf_adc_capture (2 channels, 16-bit,
//               depth 16). Capture scenarios come from a vector table; the
//               multi-cycle corner cases are hand-written sequences. Expected
//               beats are queued when the trigger is driven and popped by a
//               monitor on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_adc_capture;

    localparam int CH_NUM = 2;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic [2:0]  user;
    } beat_t;

    typedef struct {
        logic [3:0] pre;
        logic [1:0] en;
        int         trig_n;
        bit         ext;
        bit         stall;
        int         exp_start;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     arm, abort, sw_trig, ext_trig;
    logic [AW-1:0]            pre_len;
    logic [CH_NUM-1:0]        ch_en;
    logic [CH_NUM*DATA_W-1:0] s_tdata;
    logic                     s_tvalid, s_tready;
    logic [DATA_W-1:0]        m_tdata;
    logic                     m_tvalid, m_tready, m_tlast;
    logic [2:0]               m_tuser;
    logic                     busy, done;
    logic [2:0]               state;

    logic [15:0] n = 16'd0;
    logic        ramp_load;
    bit          stall_mode = 1'b0;
    bit          mon_en = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          hs_cnt = 0;
    int          done_cnt = 0;
    beat_t       exp_q[$];
    vec_t        vecs[3];

    rf_adc_capture #(.CH_NUM(CH_NUM), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .adc_usr_clk(clk),   .adc_usr_rst(rst),   .arm(arm),         .abort(abort),
        .sw_trig(sw_trig),   .ext_trig(ext_trig), .pre_len(pre_len), .ch_en(ch_en),
        .s_tdata(s_tdata),   .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata),   .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast),   .m_tuser(m_tuser),   .busy(busy),       .done(done),
        .state(state)
    );

    // Channel k carries k*256 + ramp; the ramp advances only on valid beats
    assign s_tdata = {16'd256 + n, n};
    always @(posedge clk) begin
        if (ramp_load)     n <= 16'd0;
        else if (s_tvalid) n <= n + 16'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ready pattern: toggling 1-0 with a 5-cycle stall burst every 16 cycles
    initial begin
        int c = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            c++;
            if (stall_mode)
                m_tready = ((c % 16) >= 10 && (c % 16) < 15) ? 1'b0 : 1'((c % 2) == 0);
            else
                m_tready = 1'b1;
        end
    end

    // Output monitor: scoreboard compare on handshake, stability during stalls
    initial begin
        bit                prev_stall = 1'b0;
        logic [DATA_W-1:0] prev_data = '0;
        logic              prev_last = 1'b0;
        logic [2:0]        prev_user = 3'd0;
        beat_t             e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (prev_stall) begin
                    chk("stall_valid_held", 32'(m_tvalid), 32'd1);
                    chk("stall_data_stable", 32'(m_tdata), 32'(prev_data));
                    chk("stall_last_stable", 32'(m_tlast), 32'(prev_last));
                    chk("stall_user_stable", 32'(m_tuser), 32'(prev_user));
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data 0x%0h user %0d, expected none",
                                 m_tdata, m_tuser);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", 32'(m_tdata), 32'(e.data));
                        chk("beat_last", 32'(m_tlast), 32'(e.last));
                        chk("beat_user", 32'(m_tuser), 32'(e.user));
                    end
                    hs_cnt++;
                end
                prev_stall = m_tvalid && !m_tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
                prev_user  = m_tuser;
                if (done) done_cnt++;
            end
        end
    end

    task automatic arm_cap(input logic [3:0] p, input logic [1:0] e);
        pre_len   = p;
        ch_en     = e;
        arm       = 1'b1;
        ramp_load = 1'b1;
        cyc(1);
        arm       = 1'b0;
        ramp_load = 1'b0;
        chk("busy_after_arm", 32'(busy), 32'd1);
    endtask

    task automatic wait_ramp(input int t);
        for (int i = 0; i < 1000 && n != 16'(t); i++) cyc(1);
        if (n != 16'(t)) fail_now("wait_ramp");
    endtask

    // Trigger when the ramp reaches t; expected packets start at 'start'
    task automatic fire(input int t, input bit ext, input logic [1:0] e, input int start);
        beat_t b;
        wait_ramp(t);
        for (int ch = 0; ch < CH_NUM; ch++) begin
            if (e[ch]) begin
                for (int k = 0; k < DEPTH; k++) begin
                    b.data = 16'(ch * 256 + start + k);
                    b.last = (k == DEPTH - 1);
                    b.user = 3'(ch);
                    exp_q.push_back(b);
                end
            end
        end
        if (ext) ext_trig = 1'b1;
        else     sw_trig  = 1'b1;
        cyc(1);
        sw_trig = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        for (int i = 0; i < 2000 && done_cnt == d0; i++) cyc(1);
        if (done_cnt == d0) begin
            fail_now("done_timeout");
        end else begin
            cyc(2);
            chk("done_single_pulse", 32'(done_cnt - d0), 32'd1);
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("state_idle_after", 32'(state), 32'd0);
            chk("busy_low_after", 32'(busy), 32'd0);
        end
        exp_q.delete();
    endtask

    initial begin
        int h0;
        int d0;
        rst = 1'b1; arm = 1'b0; abort = 1'b0; sw_trig = 1'b0; ext_trig = 1'b0;
        s_tvalid = 1'b1; ramp_load = 1'b0; pre_len = '0; ch_en = '0;

        vecs[0] = '{4'd4, 2'b11, 40,  1'b0, 1'b0, 36};
        vecs[1] = '{4'd4, 2'b11, 40,  1'b0, 1'b1, 36};
        vecs[2] = '{4'd0, 2'b10, 100, 1'b1, 1'b0, 100};

        cyc(3);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tready", 32'(s_tready), 32'd1);
        chk("rst_tdata", 32'(m_tdata), 32'd0);
        chk("rst_tuser", 32'(m_tuser), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // abort and arm together: abort wins
        abort = 1'b1; arm = 1'b1; pre_len = 4'd4; ch_en = 2'b11;
        cyc(1);
        abort = 1'b0; arm = 1'b0;
        chk("abort_beats_arm", 32'(state), 32'd0);

        for (int v = 0; v < 3; v++) begin
            stall_mode = vecs[v].stall;
            ext_trig   = 1'b0;
            arm_cap(vecs[v].pre, vecs[v].en);
            fire(vecs[v].trig_n, vecs[v].ext, vecs[v].en, vecs[v].exp_start);
            wait_done();
            if (vecs[v].ext) begin
                // ext_trig still high: a level without a new edge must not trigger
                h0 = hs_cnt;
                arm_cap(4'd0, vecs[v].en);
                cyc(30);
                chk("ext_level_no_trig", 32'(state), 32'd2);
                chk("ext_level_no_beats", 32'(hs_cnt - h0), 32'd0);
                abort = 1'b1;
                cyc(1);
                abort = 1'b0;
                chk("abort_from_armed", 32'(state), 32'd0);
                ext_trig = 1'b0;
            end
        end
        stall_mode = 1'b0;

        // Trigger during FILL ignored; s_tvalid gap during POST
        arm_cap(4'd8, 2'b01);
        wait_ramp(3);
        sw_trig = 1'b1;
        cyc(1);
        sw_trig = 1'b0;
        chk("fill_ignores_trig", 32'(state), 32'd1);
        fire(20, 1'b0, 2'b01, 12);
        chk("post_after_trig", 32'(state), 32'd3);
        cyc(2);
        s_tvalid = 1'b0;
        cyc(3);
        chk("post_holds_in_gap", 32'(state), 32'd3);
        s_tvalid = 1'b1;
        wait_done();

        // Abort during readout, then a clean capture
        arm_cap(4'd4, 2'b11);
        h0 = hs_cnt;
        fire(40, 1'b0, 2'b11, 36);
        for (int i = 0; i < 200 && hs_cnt < h0 + 5; i++) cyc(1);
        if (hs_cnt < h0 + 5) fail_now("wait_beat5");
        d0 = done_cnt;
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_tvalid_low", 32'(m_tvalid), 32'd0);
        chk("abort_state_idle", 32'(state), 32'd0);
        chk("abort_busy_low", 32'(busy), 32'd0);
        exp_q.delete();
        cyc(5);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        arm_cap(4'd4, 2'b01);
        fire(30, 1'b0, 2'b01, 26);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_adc_capture.md
Name: rf_adc_capture

Overview:
- Parametrised multi-channel ADC snapshot engine on one ADC user-clock domain, downstream of the RF data converter's ADC AXI4-Stream outputs.
- Continuously records all enabled channels into per-channel circular buffers with a programmable pre-trigger depth, then freezes on a trigger.
- After freezing, it replays each enabled channel as one framed packet on a single AXI4-Stream master, so a DMA can drain the snapshot.

Parameters:
- CH_NUM, 6, number of ADC stream channels (1..8)
- DATA_W, 128, bits per channel beat
- DEPTH, 1024, beats per channel buffer (power of 2, ≥4)
- AW, $clog2(DEPTH), buffer address width (derived; do not override)

Ports:
- adc_usr_clk  in  1  sole clock
- adc_usr_rst  in  1  synchronous active-high reset
- arm  in  1  one-cycle start pulse
- abort  in  1  one-cycle pulse, return to IDLE
- sw_trig  in  1  software trigger pulse
- ext_trig  in  1  external trigger level, already synchronous to adc_usr_clk
- pre_len  in  AW  pre-trigger beats, sampled at arm
- ch_en  in  CH_NUM  channel enable mask, sampled at arm
- s_tdata  in  CH_NUM*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- s_tvalid  in  1  common beat valid for all channels
- s_tready  out  1  tied 1; the ADC path cannot stall
- m_tdata  out  DATA_W  readout data
- m_tvalid  out  1  readout valid
- m_tready  in  1  readout ready
- m_tlast  out  1  last beat of a channel packet
- m_tuser  out  3  channel index of the current packet
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse when readout completes
- state  out  3  IDLE=0, FILL=1, ARMED=2, POST=3, READ=4

Behaviour:
Interface:
- One clock. Reset is synchronous and active-high: clock adc_usr_clk, reset adc_usr_rst.

Reset:
- state=IDLE.
- m_tvalid=0, m_tlast=0, m_tuser=0, m_tdata=0.
- busy=0, done=0.
- All pointers and counters cleared.
- Buffer contents are undefined.

Write path:
- In FILL, ARMED and POST, every cycle with s_tvalid=1 writes all CH_NUM lanes at wr_ptr, then wr_ptr increments mod DEPTH.

States:
- IDLE:
  - arm → latch pre_len (clamp to DEPTH-1) and ch_en; wr_ptr=0, cnt=0.
  - Next state is FILL, or ARMED if the latched pre_len=0.
- FILL:
  - cnt counts written beats.
  - When cnt reaches pre_len after a write → ARMED.
  - Triggers are ignored in FILL.
- ARMED:
  - trig = sw_trig | rising edge of ext_trig (edge register cleared at reset).
  - On trig: start_ptr = (wr_ptr - pre_len) mod DEPTH, cnt=0, → POST.
  - If s_tvalid=1 in the trigger cycle, that beat is written and is post-sample 0.
- POST:
  - Counts writes until DEPTH - pre_len post beats (including the trigger beat) are stored → READ.
  - Further triggers are ignored.
- READ:
  - Channels are visited in ascending index, skipping disabled ones.
  - For each channel, DEPTH beats are emitted from start_ptr wrapping mod DEPTH.
  - The first beat is the oldest pre-trigger sample.
  - m_tuser = channel index; m_tlast=1 on beat DEPTH-1.
  - After the last enabled channel's tlast handshake: done=1 for one cycle, → IDLE.
  - Latched ch_en=0: go to IDLE with a done pulse and emit no beats.

Readout pipeline:
- Synchronous 1-cycle RAM read feeding a 2-entry output skid buffer.
- AXI4-Stream rules apply: m_tdata, m_tlast and m_tuser are stable while m_tvalid=1 and m_tready=0; m_tvalid never drops without a handshake.
- Sustains 1 beat/cycle when m_tready stays high.
- First m_tvalid appears ≤3 cycles after entering READ.

Control edge cases:
- arm outside IDLE is ignored.
- abort in any state → IDLE next cycle: m_tvalid=0 immediately, pipeline flushed, no done pulse.
- abort and arm in the same cycle: abort wins.
- Reset mid-operation behaves like abort plus clearing counters.
- wr_ptr wraps silently. A trigger arriving before DEPTH beats exist is only possible with pre_len < DEPTH, so no beat is ever read unwritten.
- busy = (state != IDLE), registered.

Test Plan (bench: CH_NUM=2, DATA_W=16, DEPTH=16; channel k data = k*256 + free-running ramp n, s_tvalid=1):
1. Reset held 3 cycles → state=0, m_tvalid=0, busy=0, done=0. s_tready=1 throughout.
2. pre_len=4, ch_en=2'b11, arm; sw_trig when ramp=40 → ch0 packet 36..51 (16 beats, tlast on 51, tuser=0), then ch1 packet 292..307 (tuser=1), then one done pulse.
3. Same as scenario 2 with m_tready toggling 1-0-1-0 and 5-cycle stall bursts → identical beat sequence; m_tdata stable during every stall.
4. pre_len=0, ch_en=2'b10, ext_trig rises at ramp=100 → only a ch1 packet, 356..371, tuser=1. An ext_trig held high does not re-trigger.
5. pre_len=8; sw_trig during FILL (ramp=3) ignored; sw_trig at ramp=20 → ch0 packet 12..27. s_tvalid deasserted for 3 cycles in POST → the packet still contains contiguous valid-beat values.
6. abort asserted on READ beat 5 → m_tvalid=0 next cycle, state=0, no done. A new arm then captures normally.
